// File: rtl/serial_skip_adder_ctrl.sv
// rtl/serial_skip_adder_ctrl.sv - two-requester controller sharing one K-bit carry-skip slice
// A W-bit add runs one chunk per cycle; the result is held on a valid/ready port.
module serial_skip_adder_ctrl #(
  parameter int W  = 128,
  parameter int K  = 16,
  localparam int N  = W / K,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_sum,
  output logic          res_cout,
  output logic          res_id,
  output logic [CW-1:0] res_skip,
  output logic          busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N-1:0][K-1:0]  r_a;
  logic [N-1:0][K-1:0]  r_b;
  logic [N-1:0][K-1:0]  r_sum;
  logic                 r_id;
  logic                 r_last_grant;
  logic                 r_carry;
  logic                 r_cout;
  logic [CW-1:0]        r_idx;
  logic [CW-1:0]        r_skip;

  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_accept;
  logic                 w_last_chunk;
  logic [IW-1:0]        w_sel;
  logic [K-1:0]         w_ca;
  logic [K-1:0]         w_cb;
  logic [K:0]           w_csum;
  logic                 w_p;
  logic                 w_carry_nxt;

  assign w_sel        = r_idx[IW-1:0];
  assign w_ca         = r_a[w_sel];
  assign w_cb         = r_b[w_sel];
  assign w_csum       = {1'b0, w_ca} + {1'b0, w_cb} + {{K{1'b0}}, r_carry};
  assign w_p          = &(w_ca ^ w_cb);
  // A fully propagating chunk passes its incoming carry straight through.
  assign w_carry_nxt  = w_p ? r_carry : w_csum[K];
  assign w_last_chunk = (r_idx == CW'(N - 1));
  assign w_accept     = w_gnt0 || w_gnt1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time is served.
        w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
        w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
        if (w_gnt0 || w_gnt1) w_state_nxt = S_RUN;
      end
      S_RUN:   if (w_last_chunk) w_state_nxt = S_DONE;
      S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_carry      <= 1'b0;
      r_cout       <= 1'b0;
      r_idx        <= '0;
      r_skip       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a          <= w_gnt1 ? req1_a : req0_a;
        r_b          <= w_gnt1 ? req1_b : req0_b;
        r_id         <= w_gnt1;
        r_last_grant <= w_gnt1;
        r_carry      <= 1'b0;
        r_idx        <= '0;
        r_skip       <= '0;
        r_sum        <= '0;
      end else if (r_state == S_RUN) begin
        r_sum[w_sel] <= w_csum[K-1:0];
        r_carry      <= w_carry_nxt;
        r_skip       <= r_skip + CW'(w_p);
        r_idx        <= r_idx + CW'(1);
        if (w_last_chunk) r_cout <= w_carry_nxt;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign res_valid  = (r_state == S_DONE);
  assign res_sum    = r_sum;
  assign res_cout   = r_cout;
  assign res_id     = r_id;
  assign res_skip   = r_skip;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_skip_adder_ctrl.sv
// tb/tb_serial_skip_adder_ctrl.sv - scoreboard bench for serial_skip_adder_ctrl
// Expected results come from plain W+1-bit arithmetic and a timing/arbitration model.
module tb_serial_skip_adder_ctrl;
  localparam int W  = 128;
  localparam int K  = 16;
  localparam int N  = W / K;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          id;
    logic [CW-1:0] skip;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, res_ready;
  logic          req0_ready, req1_ready, res_valid;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, res_sum;
  logic          res_cout, res_id, busy;
  logic [CW-1:0] res_skip;

  serial_skip_adder_ctrl #(.W(W), .K(K)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .res_skip(res_skip), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_grants = 0;
  op_t  q0[$];
  op_t  q1[$];
  res_t exp_q[$];

  bit   m_idle    = 1'b1;
  bit   m_release = 1'b0;
  bit   tb_last   = 1'b1;
  int   m_done_cyc = 0;
  bit   hs0 = 1'b0, hs1 = 1'b0;
  int   rr_pct = 100;
  bit   rr_force0 = 1'b0;
  int   gap_pct = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_check(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic id);
    res_t         r;
    logic [W:0]   s;
    logic [W-1:0] x;
    int           sk;
    s  = {1'b0, a} + {1'b0, b};
    x  = a ^ b;
    sk = 0;
    for (int i = 0; i < N; i++)
      if (x[i*K +: K] == {K{1'b1}}) sk++;
    r.sum  = s[W-1:0];
    r.cout = s[W];
    r.id   = id;
    r.skip = CW'(sk);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    if (r == 0) q0.push_back(o);
    else q1.push_back(o);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || !m_idle) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    bound_check(name, t < 3000);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Request driver plus timing/arbitration model: decides who must be granted and when results appear.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs0 = 1'b0;
        hs1 = 1'b0;
      end else begin
        if (m_release) begin
          m_idle    = 1'b1;
          m_release = 1'b0;
        end
        check("busy", busy, !m_idle);
        check("res_valid", res_valid, !m_idle && cyc >= m_done_cyc);
        g = -1;
        if (m_idle) begin
          if (req0_valid && req1_valid) g = tb_last ? 0 : 1;
          else if (req0_valid) g = 0;
          else if (req1_valid) g = 1;
        end
        check("req0_ready", req0_ready, g == 0);
        check("req1_ready", req1_ready, g == 1);
        if (g == 0) begin
          exp_q.push_back(model(req0_a, req0_b, 1'b0));
          hs0 = 1'b1;
        end
        if (g == 1) begin
          exp_q.push_back(model(req1_a, req1_b, 1'b1));
          hs1 = 1'b1;
        end
        if (g >= 0) begin
          tb_last    = (g == 1);
          m_idle     = 1'b0;
          m_done_cyc = cyc + 1 + N;
          n_grants++;
        end
        if (!m_idle && cyc >= m_done_cyc && res_ready) m_release = 1'b1;
      end
      @(posedge clk);
      #1;
      if (hs0) begin void'(q0.pop_front()); hs0 = 1'b0; end
      if (hs1) begin void'(q1.pop_front()); hs1 = 1'b0; end
      req0_valid = (q0.size() != 0) && ($urandom_range(1, 100) > gap_pct);
      req1_valid = (q1.size() != 0) && ($urandom_range(1, 100) > gap_pct);
      if (req0_valid) begin req0_a = q0[0].a; req0_b = q0[0].b; end
      else begin req0_a = rnd_w(); req0_b = rnd_w(); end
      if (req1_valid) begin req1_a = q1[0].a; req1_b = q1[0].b; end
      else begin req1_a = rnd_w(); req1_b = rnd_w(); end
      res_ready = !rr_force0 && ($urandom_range(1, 100) <= rr_pct);
    end
  end

  // Result monitor: pops the scoreboard on each accepted result and checks hold stability.
  initial begin
    res_t held;
    res_t e;
    bit   is_held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !res_valid) begin
        is_held = 1'b0;
      end else begin
        if (is_held) begin
          check("hold_sum", res_sum, held.sum);
          check("hold_cout", res_cout, held.cout);
          check("hold_id", res_id, held.id);
          check("hold_skip", res_skip, held.skip);
        end
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got sum 0x%0h with no operation outstanding", res_sum);
          end else begin
            e = exp_q.pop_front();
            check("res_sum", res_sum, e.sum);
            check("res_cout", res_cout, e.cout);
            check("res_id", res_id, e.id);
            check("res_skip", res_skip, e.skip);
          end
          is_held = 1'b0;
        end else begin
          held.sum  = res_sum;
          held.cout = res_cout;
          held.id   = res_id;
          held.skip = res_skip;
          is_held   = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] a, b;
    int           t, ng, j;
    ones = '1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_cout", res_cout, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_skip", res_skip, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    push_op(0, 127, 45);
    wait_drain("drain_small");
    push_op(1, 128'hFFFF, 128'h1);
    wait_drain("drain_chunk_carry");
    push_op(0, ones, '0);
    push_op(0, ones, 128'h1);
    wait_drain("drain_all_ones");

    // Result held in DONE while the other requester waits.
    rr_force0 = 1'b1;
    push_op(0, rnd_w(), rnd_w());
    push_op(1, rnd_w(), rnd_w());
    t = 0;
    while (!res_valid && t < 200) begin @(posedge clk); #2; t++; end
    bound_check("wait_done_hold", t < 200);
    repeat (5) @(posedge clk);
    #2 rr_force0 = 1'b0;
    wait_drain("drain_hold");

    // Reset in the middle of RUN, then a tie must go to requester 0.
    ng = n_grants;
    push_op(0, rnd_w(), rnd_w());
    t = 0;
    while (n_grants == ng && t < 100) begin @(posedge clk); t++; end
    bound_check("wait_grant_rst", t < 100);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_res_valid", res_valid, 0);
    check("midrun_busy", busy, 0);
    check("midrun_req0_ready", req0_ready, 0);
    exp_q.delete();
    m_idle = 1'b1; m_release = 1'b0; tb_last = 1'b1; hs0 = 1'b0; hs1 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_op(0, rnd_w(), rnd_w());
      push_op(1, rnd_w(), rnd_w());
    end
    wait_drain("drain_alternate");

    gap_pct = 30;
    rr_pct  = 60;
    for (int i = 0; i < 30; i++) begin
      a = rnd_w();
      case ($urandom_range(0, 3))
        0: b = rnd_w();
        1: b = ~a;
        2: begin
          b = ~a;
          j = $urandom_range(0, N - 1);
          b[j*K +: K] = K'($urandom);
        end
        default: begin
          a = ones >> $urandom_range(0, W - 1);
          b = W'($urandom_range(0, 3));
        end
      endcase
      push_op($urandom_range(0, 1), a, b);
      if ($urandom_range(0, 2) == 0) wait_drain("drain_random_step");
    end
    wait_drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
